// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Receiving end of the fetch-to-decode bundle interface. Accepts
//               up to four instructions per cycle from fetch, stores them in
//               order in a circular buffer, and presents the two oldest
//               entries (instruction + PC) to decode. A flush discards all
//               buffered contents.
// Ports       : clk, rst_n        - clock (rising edge), async active-low reset
//               flush             - discard all entries (synchronous)
//               in_valid, in_pc,
//               in_inst, in_count - fetch bundle (slot i PC = in_pc + 4*i)
//               in_ready          - room for a full 4-entry bundle
//               out_valid[1:0]    - head / head+1 entry valid
//               out_inst0/1,
//               out_pc0/1         - head and head+1 entry contents
//               out_pop           - entries consumed by decode this cycle
//               occupancy         - current entry count
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH  = 16,
    parameter int INST_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [4*INST_W-1:0]        in_inst,
    input  logic [2:0]                 in_count,
    output logic                       in_ready,
    output logic [1:0]                 out_valid,
    output logic [INST_W-1:0]          out_inst0,
    output logic [INST_W-1:0]          out_inst1,
    output logic [31:0]                out_pc0,
    output logic [31:0]                out_pc1,
    input  logic [1:0]                 out_pop,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 32 + INST_W;

    // Storage is deliberately left unreset; valid tracking comes from r_count.
    logic [ENTRY_W-1:0] r_mem [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [2:0]       w_push_n;
    logic [1:0]       w_pop_lim;
    logic [1:0]       w_pop_n;
    logic [PTR_W-1:0] w_head1;
    logic             w_push_ok;

    // Readiness looks only at the registered count, never at same-cycle pops,
    // so fetch sees a timing-clean ready signal.
    assign in_ready  = (r_count <= CNT_W'(DEPTH - 4));
    assign w_push_ok = in_valid && in_ready && !flush;

    always_comb begin
        w_push_n = 3'd0;
        if (w_push_ok) begin
            w_push_n = (in_count > 3'd4) ? 3'd4 : in_count;
        end
    end

    // Decode can never consume more than is present, nor more than the two
    // entries it can see; an over-sized request is clamped.
    always_comb begin
        w_pop_lim = (r_count < CNT_W'(2)) ? r_count[1:0] : 2'd2;
        w_pop_n   = 2'd0;
        if (!flush) begin
            w_pop_n = (out_pop > w_pop_lim) ? w_pop_lim : out_pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop_n);
            r_tail  <= r_tail + PTR_W'(w_push_n);
            r_count <= r_count + CNT_W'(w_push_n) - CNT_W'(w_pop_n);
        end
    end

    // Slot i lands at (tail + i) mod DEPTH; pointer width gives the wrap, so
    // a bundle may straddle the end of the buffer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < w_push_n) begin
                r_mem[r_tail + PTR_W'(i)] <= {in_pc + 32'(4 * i),
                                              in_inst[i*INST_W +: INST_W]};
            end
        end
    end

    assign w_head1 = r_head + PTR_W'(1);

    assign out_pc0   = r_mem[r_head][ENTRY_W-1 -: 32];
    assign out_inst0 = r_mem[r_head][INST_W-1:0];
    assign out_pc1   = r_mem[w_head1][ENTRY_W-1 -: 32];
    assign out_inst1 = r_mem[w_head1][INST_W-1:0];

    // During a flush cycle nothing may be handed to decode.
    assign out_valid = flush ? 2'b00
                             : {(r_count >= CNT_W'(2)), (r_count >= CNT_W'(1))};
    assign occupancy = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking directed testbench for fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH  = 16;
    localparam int INST_W = 32;
    localparam logic [31:0] C_XOR = 32'h5A5A_0000;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush;
    logic                   in_valid;
    logic [31:0]            in_pc;
    logic [4*INST_W-1:0]    in_inst;
    logic [2:0]             in_count;
    logic                   in_ready;
    logic [1:0]             out_valid;
    logic [INST_W-1:0]      out_inst0;
    logic [INST_W-1:0]      out_inst1;
    logic [31:0]            out_pc0;
    logic [31:0]            out_pc1;
    logic [1:0]             out_pop;
    logic [$clog2(DEPTH):0] occupancy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int viol_cnt  = 0;

    fetch_queue #(.DEPTH(DEPTH), .INST_W(INST_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_count  (in_count),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_inst0 (out_inst0),
        .out_inst1 (out_inst1),
        .out_pc0   (out_pc0),
        .out_pc1   (out_pc1),
        .out_pop   (out_pop),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Protocol monitor: decode asking for more than is present.
    always @(posedge clk) begin
        if (rst_n && !flush && ({1'b0, out_pop} > occupancy)) begin
            viol_cnt++;
            $display("NOTE protocol violation: out_pop=%0d occupancy=%0d", out_pop, occupancy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4*INST_W-1:0] mk_bundle(input logic [31:0] pc);
        logic [4*INST_W-1:0] b;
        for (int j = 0; j < 4; j++) b[j*INST_W +: INST_W] = (pc + 32'(4*j)) ^ C_XOR;
        return b;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] cnt,
                         input logic [4*INST_W-1:0] inst, input logic [1:0] pop,
                         input logic fl);
        in_valid = v; in_pc = pc; in_count = cnt; in_inst = inst;
        out_pop = pop; flush = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 3'd0, '0, 2'd0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #2;
        total_cnt++; if (occupancy !== 5'd0) $display("FAIL reset_occ: got %0d expected 0", occupancy); else pass_cnt++;
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL reset_valid: got %b expected 00", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", in_ready); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_push();
        do_reset();
        drive(1'b1, 32'h1000, 3'd4, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 2'd0, 1'b0);
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL basic_no_bypass: got %b expected 00", out_valid); else pass_cnt++;
        tick();
        idle();
        total_cnt++; if (out_valid !== 2'b11) $display("FAIL basic_valid: got %b expected 11", out_valid); else pass_cnt++;
        total_cnt++; if (out_inst0 !== 32'hAAAA_0001) $display("FAIL basic_inst0: got %h expected aaaa0001", out_inst0); else pass_cnt++;
        total_cnt++; if (out_pc0 !== 32'h1000) $display("FAIL basic_pc0: got %h expected 00001000", out_pc0); else pass_cnt++;
        total_cnt++; if (out_inst1 !== 32'hBBBB_0002) $display("FAIL basic_inst1: got %h expected bbbb0002", out_inst1); else pass_cnt++;
        total_cnt++; if (out_pc1 !== 32'h1004) $display("FAIL basic_pc1: got %h expected 00001004", out_pc1); else pass_cnt++;
        total_cnt++; if (occupancy !== 5'd4) $display("FAIL basic_occ: got %0d expected 4", occupancy); else pass_cnt++;
    endtask

    task automatic test_partial_push();
        do_reset();
        drive(1'b1, 32'h2008, 3'd2, {64'h0, 32'h2222_0002, 32'h1111_0001}, 2'd0, 1'b0);
        tick();
        idle();
        total_cnt++; if (occupancy !== 5'd2) $display("FAIL partial_occ: got %0d expected 2", occupancy); else pass_cnt++;
        total_cnt++; if (out_pc1 !== 32'h200C) $display("FAIL partial_pc1: got %h expected 0000200c", out_pc1); else pass_cnt++;
        drive(1'b0, 32'h0, 3'd0, '0, 2'd1, 1'b0);
        tick();
        idle();
        total_cnt++; if (out_valid !== 2'b01) $display("FAIL partial_pop_valid: got %b expected 01", out_valid); else pass_cnt++;
        total_cnt++; if (out_pc0 !== 32'h200C) $display("FAIL partial_pop_pc0: got %h expected 0000200c", out_pc0); else pass_cnt++;
        total_cnt++; if (out_inst0 !== 32'h2222_0002) $display("FAIL partial_pop_inst0: got %h expected 22220002", out_inst0); else pass_cnt++;
    endtask

    task automatic test_count_clamp();
        do_reset();
        drive(1'b1, 32'h3000, 3'd0, mk_bundle(32'h3000), 2'd0, 1'b0);
        tick();
        total_cnt++; if (occupancy !== 5'd0) $display("FAIL count0_occ: got %0d expected 0", occupancy); else pass_cnt++;
        drive(1'b1, 32'h3000, 3'd7, mk_bundle(32'h3000), 2'd0, 1'b0);
        tick();
        idle();
        total_cnt++; if (occupancy !== 5'd4) $display("FAIL count7_occ: got %0d expected 4", occupancy); else pass_cnt++;
        total_cnt++; if (out_pc1 !== 32'h3004) $display("FAIL count7_pc1: got %h expected 00003004", out_pc1); else pass_cnt++;
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h4000 + 32'(16*k), 3'd4, mk_bundle(32'h4000 + 32'(16*k)), 2'd0, 1'b0);
            tick();
            idle();
            total_cnt++; if (occupancy !== 5'(4*(k+1))) $display("FAIL fill_occ_%0d: got %0d expected %0d", k, occupancy, 4*(k+1)); else pass_cnt++;
            total_cnt++; if (in_ready !== (k < 3)) $display("FAIL fill_ready_%0d: got %b expected %b", k, in_ready, (k < 3)); else pass_cnt++;
        end
        drive(1'b1, 32'h8000, 3'd4, mk_bundle(32'h8000), 2'd0, 1'b0);
        tick();
        idle();
        total_cnt++; if (occupancy !== 5'd16) $display("FAIL fill_ignored_occ: got %0d expected 16", occupancy); else pass_cnt++;
        total_cnt++; if (out_pc0 !== 32'h4000) $display("FAIL fill_head_pc: got %h expected 00004000", out_pc0); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int          exp_cnt;
        logic [31:0] next_in;
        logic [31:0] next_out;
        logic        do_push;
        logic [1:0]  pop;
        do_reset();
        exp_cnt  = 0;
        next_in  = 32'h5000;
        next_out = 32'h5000;
        for (int k = 0; k < 24; k++) begin
            do_push = (exp_cnt <= DEPTH - 4);
            pop     = (exp_cnt >= 2) ? 2'd2 : 2'd0;
            total_cnt++; if (occupancy !== 5'(exp_cnt)) $display("FAIL b2b_occ_%0d: got %0d expected %0d", k, occupancy, exp_cnt); else pass_cnt++;
            total_cnt++; if (in_ready !== do_push) $display("FAIL b2b_ready_%0d: got %b expected %b", k, in_ready, do_push); else pass_cnt++;
            if (pop == 2'd2) begin
                total_cnt++; if (out_pc0 !== next_out) $display("FAIL b2b_pc0_%0d: got %h expected %h", k, out_pc0, next_out); else pass_cnt++;
                total_cnt++; if (out_pc1 !== next_out + 32'd4) $display("FAIL b2b_pc1_%0d: got %h expected %h", k, out_pc1, next_out + 32'd4); else pass_cnt++;
                total_cnt++; if (out_inst1 !== ((next_out + 32'd4) ^ C_XOR)) $display("FAIL b2b_inst1_%0d: got %h expected %h", k, out_inst1, (next_out + 32'd4) ^ C_XOR); else pass_cnt++;
            end
            drive(1'b1, next_in, 3'd4, mk_bundle(next_in), pop, 1'b0);
            tick();
            if (do_push) begin
                next_in = next_in + 32'd16;
                exp_cnt = exp_cnt + 4;
            end
            if (pop == 2'd2) begin
                next_out = next_out + 32'd8;
                exp_cnt  = exp_cnt - 2;
            end
        end
        idle();
    endtask

    task automatic test_pop_clamp();
        int v0;
        do_reset();
        drive(1'b1, 32'h6000, 3'd1, mk_bundle(32'h6000), 2'd0, 1'b0);
        tick();
        v0 = viol_cnt;
        drive(1'b0, 32'h0, 3'd0, '0, 2'd2, 1'b0);
        tick();
        idle();
        total_cnt++; if (occupancy !== 5'd0) $display("FAIL clamp_occ: got %0d expected 0", occupancy); else pass_cnt++;
        total_cnt++; if (viol_cnt - v0 !== 1) $display("FAIL clamp_flagged: got %0d expected 1", viol_cnt - v0); else pass_cnt++;
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 32'h7000, 3'd4, mk_bundle(32'h7000), 2'd0, 1'b0);
        tick();
        drive(1'b1, 32'h7010, 3'd4, mk_bundle(32'h7010), 2'd1, 1'b0);
        tick();
        total_cnt++; if (occupancy !== 5'd7) $display("FAIL flush_pre_occ: got %0d expected 7", occupancy); else pass_cnt++;
        drive(1'b1, 32'h9000, 3'd4, mk_bundle(32'h9000), 2'd2, 1'b1);
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL flush_cycle_valid: got %b expected 00", out_valid); else pass_cnt++;
        tick();
        idle();
        total_cnt++; if (occupancy !== 5'd0) $display("FAIL flush_occ: got %0d expected 0", occupancy); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_ready: got %b expected 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL flush_after_valid: got %b expected 00", out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (occupancy !== 5'd0) $display("FAIL flush_no_leak: got %0d expected 0", occupancy); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 32'hA000, 3'd4, mk_bundle(32'hA000), 2'd0, 1'b0);
        tick();
        drive(1'b1, 32'hA010, 3'd4, mk_bundle(32'hA010), 2'd0, 1'b0);
        tick();
        drive(1'b1, 32'hA020, 3'd1, mk_bundle(32'hA020), 2'd0, 1'b0);
        tick();
        idle();
        total_cnt++; if (occupancy !== 5'd9) $display("FAIL areset_pre_occ: got %0d expected 9", occupancy); else pass_cnt++;
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (occupancy !== 5'd0) $display("FAIL areset_occ: got %0d expected 0", occupancy); else pass_cnt++;
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL areset_valid: got %b expected 00", out_valid); else pass_cnt++;
        #1;
        rst_n = 1'b1;
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL areset_ready: got %b expected 1", in_ready); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_push();
        test_partial_push();
        test_count_clamp();
        test_fill();
        test_back_to_back();
        test_pop_clamp();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
